// File: rtl/gray_pkg.sv
// Shared constants for the Gray-converter arbiter: FSM encodings and default sizes.
package gray_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Default geometry
  localparam int DEF_W     = 4;
  localparam int DEF_N_REQ = 4;

endpackage : gray_pkg

// File: rtl/gray_core.sv
// Shared combinational binary-to-Gray converter.
// Each Gray bit is the XOR of a binary bit and its upper neighbour, and the MSB
// passes straight through.
module gray_core #(
  parameter int W = gray_pkg::DEF_W
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  // Gray = bin XOR (bin >> 1); the shift inserts a zero at the MSB so g[W-1] = b[W-1]
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule : gray_core

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter between N_REQ
// requesters. The winner's word is latched together with its Gray code. The
// result is presented on a valid/ready port. The winner receives a one-cycle
// ack once the consumer accepts the result.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_gray,
  output logic [W-1:0]       out_bin,
  output logic [IDW-1:0]     out_id,
  output logic               busy
);

  logic [1:0]     state_r;
  logic [IDW-1:0] rr_ptr_r;

  logic           pick_found_s;
  logic [IDW-1:0] pick_id_s;
  logic [W-1:0]   pick_word_s;
  logic [W-1:0]   pick_gray_s;

  // Round-robin pick: scan from the highest offset down so the lowest offset from rr_ptr wins
  always_comb begin
    int idx_v;
    idx_v        = 0;
    pick_found_s = 1'b0;
    pick_id_s    = {IDW{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_v        = (int'(rr_ptr_r) + k) % N_REQ;
      pick_found_s = pick_found_s | req[idx_v];
      pick_id_s    = req[idx_v] ? IDW'(idx_v) : pick_id_s;
    end
  end

  // Route the candidate winner's word to the shared converter
  always_comb begin
    pick_word_s = req_data[int'(pick_id_s)*W +: W];
  end

  gray_core #(.W(W)) u_core (
    .bin  (pick_word_s),
    .gray (pick_gray_s)
  );

  // Arbitration FSM: IDLE grants and captures, HOLD waits for the consumer, ACK pulses the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= {IDW{1'b0}};
      out_valid <= 1'b0;
      out_gray  <= {W{1'b0}};
      out_bin   <= {W{1'b0}};
      out_id    <= {IDW{1'b0}};
      req_ack   <= {N_REQ{1'b0}};
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          req_ack <= {N_REQ{1'b0}};
          if (pick_found_s) begin
            out_bin   <= pick_word_s;
            out_gray  <= pick_gray_s;
            out_id    <= pick_id_s;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_HOLD;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << out_id;
            rr_ptr_r  <= (out_id == IDW'(N_REQ - 1)) ? {IDW{1'b0}} : out_id + {{(IDW-1){1'b0}}, 1'b1};
            state_r   <= ST_ACK;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_ACK: begin
          // No arbitration here so the acked requester has a cycle to drop req
          req_ack <= {N_REQ{1'b0}};
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          req_ack   <= {N_REQ{1'b0}};
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : gray_conv_arbiter

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Round-robin arbiter that shares one binary-to-Gray converter between N_REQ requesters. It grants one requester at a time, latches that requester's binary word, and presents the converted Gray code on a registered valid/ready output port. When the consumer accepts the result, the block returns a one-cycle acknowledge pulse to the winning requester. It sits between lab-level producers (counters, switch samplers) and any Gray-coded consumer, such as a display or a clock-domain crossing pointer.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 4, data width in bits
IDW, $clog2(N_REQ), width of the requester index (derived; not overridden)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  request per requester; held high with stable data until its ack
req_data  in  N_REQ*W  packed binary words; requester i occupies bits [i*W +: W]
req_ack  out  N_REQ  one-cycle pulse to requester i when its word has been accepted downstream
out_valid  out  1  out_gray, out_bin and out_id are valid
out_ready  in  1  consumer accepts when out_valid && out_ready
out_gray  out  W  Gray code of the granted word
out_bin  out  W  original binary word (for checking)
out_id  out  IDW  index of the granted requester
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, out_valid=0, out_gray=0, out_bin=0, out_id=0, req_ack=0, busy=0.
- Conversion rule: g[W-1]=b[W-1]; g[i]=b[i+1]^b[i] for i<W-1. The conversion is purely combinational inside the shared core and is registered at capture.
- FSM states: IDLE, HOLD, ACK.
  - IDLE: if any req bit is high, choose the first set bit at or above rr_ptr, wrapping modulo N_REQ. Latch out_bin=word, out_gray=gray(word), out_id=winner. Set out_valid=1 and go to HOLD. If no request, stay in IDLE.
  - HOLD: out_valid=1 and all outputs are stable. On out_valid && out_ready: out_valid goes to 0 next cycle, req_ack[out_id] pulses for exactly one cycle, rr_ptr becomes (out_id+1) mod N_REQ, and the FSM goes to ACK.
  - ACK: req_ack pulse is high during this cycle only. The FSM returns to IDLE next cycle. Arbitration in ACK is suppressed so the acked requester can drop req.
- Latency: request seen in IDLE at edge k gives out_valid=1 after edge k. Minimum throughput is one word per 3 cycles.
- Simultaneous requests: round-robin fairness. A requester that is continuously requesting is granted within N_REQ grants.
- Requester drops req while in HOLD: the captured word still completes and the ack still pulses. No abort.
- out_ready high in IDLE or ACK: ignored.
- req_data changes while in HOLD: no effect, because the output is latched.
- rst mid-operation: returns to reset values at the next edge. Any pending result is discarded and no ack is issued.
- rr_ptr wraps from N_REQ-1 to 0.

Decomposition:
- Shared package/header `gray_pkg`: localparams for state encodings (IDLE=2'd0, HOLD=2'd1, ACK=2'd2) and default W/N_REQ.
- Sub-module `gray_core` (parameter W): combinational binary-to-Gray conversion, instantiated once.
- The round-robin pick stays inline in the arbiter.

Test Plan:
- Single request: req=0001, req_data[3:0]=4'b0100 -> out_valid after 1 edge, out_gray=0110, out_id=0. With out_ready=1, req_ack=0001 for one cycle.
- Conversion sweep via requester 2: inputs 0001, 0010, 0011, 1000, 1111 -> out_gray 0001, 0011, 0010, 1100, 1000.
- Round-robin: req=1111 held, words 0001/0010/0011/0100, out_ready=1 -> out_id order 0,1,2,3,0. Ack pulses follow the same order.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, no ack. Raising out_ready gives exactly one transfer and one ack.
- Requester 1 drops req during HOLD -> result still delivered with out_id=1 and req_ack[1] pulsed.
- Reset in HOLD: rst=1 for one cycle -> out_valid=0 and req_ack=0 next cycle. Afterward, req=1000 is granted (rr_ptr=0 scan reaches 3).
